// File: rtl/alu_serial_pkg.sv
// Purpose : shared encodings and constants for the nibble-serial 16-bit ALU.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package alu_serial_pkg;

   localparam int DATA_W  = 16;
   localparam int NIB_W   = 4;
   localparam int NIB_CNT = 4;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_NOT = 2'b10,
      OP_NEG = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_DONE = 2'b10
   } state_e;

   // Operation context captured when a request is accepted.
   typedef struct packed {
      op_e               op;
      logic [DATA_W-1:0] x;
      logic [DATA_W-1:0] y;
   } opnd_t;

endpackage

// File: rtl/negator_16.sv
// Purpose : 16-bit bitwise complement stage feeding the serial ALU.
// Latency : combinational, zero cycles.
// Backpressure: none, pure function of its input.
// Ports   : a (16b in), y (16b out) = ~a.
module negator_16 (
   input  logic [15:0] a,
   output logic [15:0] y
);

   assign y = ~a;

endmodule

// File: rtl/nibble_adder_4.sv
// Purpose : 4-bit ripple-carry slice used once per cycle by the serial ALU.
// Latency : combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
// Ports   : a, b (4b in), cin (in); sum (4b out), c_out (out),
//           c3 (carry into bit 3, used for signed overflow).
module nibble_adder_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       c_out,
   output logic       c3
);

   logic [4:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < 4; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign c_out = c[4];
   assign c3    = c[3];

endmodule

// File: rtl/alu_serial_16.sv
// Purpose : 16-bit ADD/SUB/NOT/NEG computed one nibble per cycle, LSB first.
// Latency : DONE five cycles after the START cycle, fixed for every OP.
// Backpressure: START ignored while BUSY (no queueing); accepted in IDLE or DONE.
// Ports   : CLK, RST (sync, active-high); START/OP/A/B request inputs;
//           BUSY, DONE status; Y result with CARRY/ZERO/OVF flags, all registered.
module alu_serial_16
   import alu_serial_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [1:0]  OP,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic        BUSY,
   output logic        DONE,
   output logic [15:0] Y,
   output logic        CARRY,
   output logic        ZERO,
   output logic        OVF
);

   state_e      state_q, state_d;
   opnd_t       opnd_q, opnd_d;
   logic [1:0]  idx_q, idx_d;
   logic        carry_run_q, carry_run_d;
   logic [15:0] y_q, y_d;
   logic        carry_q, carry_d;
   logic        zero_q, zero_d;
   logic        ovf_q, ovf_d;

   logic        accept;
   logic [15:0] neg_in, neg_out;
   logic [3:0]  nib_x, nib_y, nib_sum;
   logic        nib_cout, nib_c3;
   logic [3:0]  nib_base;

   // A request is taken whenever no nibble work is in flight.
   assign accept = START && (state_q != S_CALC);

   // SUB complements B; NEG and NOT complement A.
   assign neg_in = (OP == OP_SUB) ? B : A;

   negator_16 u_neg (
      .a (neg_in),
      .y (neg_out)
   );

   assign nib_base = {idx_q, 2'b00};
   assign nib_x    = opnd_q.x[nib_base +: NIB_W];
   assign nib_y    = opnd_q.y[nib_base +: NIB_W];

   nibble_adder_4 u_add (
      .a     (nib_x),
      .b     (nib_y),
      .cin   (carry_run_q),
      .sum   (nib_sum),
      .c_out (nib_cout),
      .c3    (nib_c3)
   );

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (START) state_d = S_CALC;
         S_CALC:  if (idx_q == 2'(NIB_CNT-1)) state_d = S_DONE;
         S_DONE:  state_d = START ? S_CALC : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      opnd_d      = opnd_q;
      idx_d       = idx_q;
      carry_run_d = carry_run_q;
      y_d         = y_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;

      if (accept) begin
         opnd_d.op = op_e'(OP);
         idx_d     = '0;
         case (op_e'(OP))
            OP_ADD: begin opnd_d.x = A;  opnd_d.y = B;       carry_run_d = 1'b0; end
            OP_SUB: begin opnd_d.x = A;  opnd_d.y = neg_out; carry_run_d = 1'b1; end
            OP_NEG: begin opnd_d.x = '0; opnd_d.y = neg_out; carry_run_d = 1'b1; end
            default: begin opnd_d.x = '0; opnd_d.y = neg_out; carry_run_d = 1'b0; end
         endcase
      end else if (state_q == S_CALC) begin
         y_d[nib_base +: NIB_W] = nib_sum;
         carry_run_d            = nib_cout;
         idx_d                  = idx_q + 2'd1;
         if (idx_q == 2'(NIB_CNT-1)) begin
            // Top-bit carry-in vs carry-out disagreement is signed overflow.
            carry_d = (opnd_q.op != OP_NOT) && nib_cout;
            ovf_d   = (opnd_q.op != OP_NOT) && (nib_c3 ^ nib_cout);
            zero_d  = ({nib_sum, y_q[11:0]} == 16'h0000);
         end
      end
   end

   // Datapath registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         opnd_q      <= '0;
         idx_q       <= '0;
         carry_run_q <= 1'b0;
         y_q         <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         opnd_q      <= opnd_d;
         idx_q       <= idx_d;
         carry_run_q <= carry_run_d;
         y_q         <= y_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
      end
   end

   // Outputs decode registered state only
   always_comb begin
      BUSY  = (state_q == S_CALC);
      DONE  = (state_q == S_DONE);
      Y     = y_q;
      CARRY = carry_q;
      ZERO  = zero_q;
      OVF   = ovf_q;
   end

endmodule

// File: tb/tb_alu_serial_16.sv
module tb_alu_serial_16;
   import alu_serial_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic [1:0]  OP;
   logic [15:0] A, B;
   logic        BUSY, DONE, CARRY, ZERO, OVF;
   logic [15:0] Y;

   int n_chk  = 0;
   int n_fail = 0;

   alu_serial_16 dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .OP    (OP),
      .A     (A),
      .B     (B),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .Y     (Y),
      .CARRY (CARRY),
      .ZERO  (ZERO),
      .OVF   (OVF)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Drive a request for one cycle, then scramble the inputs.
   task automatic start_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      START = 1'b1; OP = op; A = a; B = b;
      @(negedge CLK);
      START = 1'b0;
      OP    = ~op;
      A     = 16'($urandom);
      B     = 16'($urandom);
   endtask

   // Called in cycle t+1; returns in the DONE cycle t+5.
   task automatic expect_result(input string tag, input logic [15:0] ey,
                                input logic ec, input logic ez, input logic ev);
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_busy"}, BUSY, 1'b1);
         chk({tag, "_early_done"}, DONE, 1'b0);
         @(negedge CLK);
      end
      chk({tag, "_done"}, DONE, 1'b1);
      chk({tag, "_busy_at_done"}, BUSY, 1'b0);
      chk({tag, "_y"}, Y, ey);
      chk({tag, "_carry"}, CARRY, ec);
      chk({tag, "_zero"}, ZERO, ez);
      chk({tag, "_ovf"}, OVF, ev);
   endtask

   task automatic idle_after(input string tag, input logic [15:0] ey);
      @(negedge CLK);
      chk({tag, "_done_pulse"}, DONE, 1'b0);
      chk({tag, "_idle"}, BUSY, 1'b0);
      chk({tag, "_y_hold"}, Y, ey);
   endtask

   initial begin
      RST = 1'b1; START = 1'b0; OP = 2'b00; A = '0; B = '0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_done", DONE, 1'b0);
      chk("rst_y", Y, 16'h0000);
      chk("rst_carry", CARRY, 1'b0);
      chk("rst_zero", ZERO, 1'b0);
      chk("rst_ovf", OVF, 1'b0);
      @(negedge CLK);

      start_op(OP_ADD, 16'h1234, 16'h0FCD);
      expect_result("add1", 16'h2201, 1'b0, 1'b0, 1'b0);
      idle_after("add1", 16'h2201);

      start_op(OP_ADD, 16'hFFFF, 16'h0001);
      expect_result("add2", 16'h0000, 1'b1, 1'b1, 1'b0);
      idle_after("add2", 16'h0000);

      start_op(OP_SUB, 16'h0005, 16'h0007);
      expect_result("sub1", 16'hFFFE, 1'b0, 1'b0, 1'b0);
      idle_after("sub1", 16'hFFFE);

      start_op(OP_SUB, 16'h8000, 16'h0001);
      expect_result("sub2", 16'h7FFF, 1'b1, 1'b0, 1'b1);
      idle_after("sub2", 16'h7FFF);

      start_op(OP_NEG, 16'h8000, 16'h1234);
      expect_result("neg1", 16'h8000, 1'b0, 1'b0, 1'b1);
      idle_after("neg1", 16'h8000);

      start_op(OP_NEG, 16'h0000, 16'hFFFF);
      expect_result("neg0", 16'h0000, 1'b1, 1'b1, 1'b0);
      idle_after("neg0", 16'h0000);

      start_op(OP_NEG, 16'h0001, 16'h0000);
      expect_result("neg2", 16'hFFFF, 1'b0, 1'b0, 1'b0);
      idle_after("neg2", 16'hFFFF);

      start_op(OP_NOT, 16'h00FF, 16'hFFFF);
      expect_result("not1", 16'hFF00, 1'b0, 1'b0, 1'b0);
      idle_after("not1", 16'hFF00);

      start_op(OP_NOT, 16'hFFFF, 16'h0001);
      expect_result("not2", 16'h0000, 1'b0, 1'b1, 1'b0);
      idle_after("not2", 16'h0000);

      // START during CALC cycle 2 must be dropped
      start_op(OP_ADD, 16'h0001, 16'h0002);
      @(negedge CLK);
      START = 1'b1; OP = OP_NEG; A = 16'h5555; B = 16'h0000;
      @(negedge CLK);
      START = 1'b0;
      chk("ign_busy3", BUSY, 1'b1);
      @(negedge CLK);
      chk("ign_busy4", BUSY, 1'b1);
      @(negedge CLK);
      chk("ign_done", DONE, 1'b1);
      chk("ign_y", Y, 16'h0003);
      chk("ign_carry", CARRY, 1'b0);
      chk("ign_ovf", OVF, 1'b0);
      idle_after("ign", 16'h0003);

      // Back-to-back: second request issued in the DONE cycle
      start_op(OP_ADD, 16'h1111, 16'h2222);
      expect_result("b2b1", 16'h3333, 1'b0, 1'b0, 1'b0);
      start_op(OP_SUB, 16'h0010, 16'h0001);
      expect_result("b2b2", 16'h000F, 1'b1, 1'b0, 1'b0);
      idle_after("b2b2", 16'h000F);

      // Reset during second CALC cycle aborts the operation
      start_op(OP_ADD, 16'h1234, 16'h1111);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("abort_busy", BUSY, 1'b0);
      chk("abort_done", DONE, 1'b0);
      chk("abort_y", Y, 16'h0000);
      chk("abort_carry", CARRY, 1'b0);
      chk("abort_zero", ZERO, 1'b0);
      chk("abort_ovf", OVF, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         chk("abort_no_done", DONE, 1'b0);
         chk("abort_no_busy", BUSY, 1'b0);
      end

      start_op(OP_NEG, 16'h0001, 16'h0000);
      expect_result("post_rst", 16'hFFFF, 1'b0, 1'b0, 1'b0);
      idle_after("post_rst", 16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_serial_16.md
# alu_serial_16

Multi-cycle 16-bit arithmetic unit that sits directly downstream of the 16-bit bitwise complement stage (NEGATOR_16) in the execute path. It computes ADD, SUB, NOT and NEG on latched operands one nibble per cycle, LSB first, through a 4-bit ripple slice. It reports result and flags with a START/DONE handshake. SUB and NEG take their inverted operand from the NEGATOR_16 output and add a carry-in of 1.

## Interface
Parameters:
- None. Width is fixed at 16 bits, processed as 4 nibbles.

Ports:
- CLK  in  1  sole clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request. Sampled only when the unit is not BUSY.
- OP  in  2  operation select:
  - 00 ADD: A+B
  - 01 SUB: A+~B+1
  - 10 NOT: ~A
  - 11 NEG: 0+~A+1
- A  in  16  operand A. Sampled with START.
- B  in  16  operand B. Sampled with START; ignored for NOT and NEG.
- BUSY  out  1  high while nibbles are being computed.
- DONE  out  1  one-cycle pulse; Y and the flags are valid from this cycle on.
- Y  out  16  result. Held until the next accepted START or RST.
- CARRY  out  1  carry out of bit 15.
- ZERO  out  1  high when Y==0.
- OVF  out  1  signed two's-complement overflow.

## Operation
States:
- IDLE:
  - START=1 latches OP, A, and the operand-X / operand-Y / carry-in selection, clears the nibble index, and moves to CALC.
- CALC:
  - Each cycle adds nibble[idx] of the latched X and Y with the running carry.
  - Writes the sum into Y[4*idx+3:4*idx] and stores the carry.
  - idx==3 moves to DONE_S.
- DONE_S:
  - Asserts DONE for one cycle.
  - START=1 is accepted in this cycle, with the same latching as IDLE, and moves to CALC; otherwise moves to IDLE.

Operand and carry-in selection (X / Y / carry-in):
- ADD: A / B / 0.
- SUB: A / NEGATOR_16(B) / 1.
- NEG: 0 / NEGATOR_16(A) / 1.
- NOT: 0 / NEGATOR_16(A) / 0.

Flags, registered at the transition into DONE_S:
- CARRY: final carry. Forced to 0 for NOT. For SUB, CARRY=1 means no borrow.
- OVF: (X[15]==Y[15]) && (Y_result[15]!=X[15]), where X and Y are the selected adder operands. Forced to 0 for NOT.
- ZERO: evaluated on the full 16-bit result.

Boundary cases:
- START while BUSY is ignored; there is no queueing.
- RST in any state:
  - Returns to IDLE.
  - Clears Y, CARRY, ZERO, OVF, BUSY and DONE.
  - Aborts any in-flight operation; no DONE is produced for it.
- Y bits of nibbles not yet computed hold their previous values during CALC. Consumers use Y only at or after DONE.
- A and B may change freely after the START cycle.

## Timing
- Reset values: BUSY=0, DONE=0, Y=0x0000, CARRY=0, ZERO=0, OVF=0; state is IDLE.
- Latency for a START sampled at edge t:
  - BUSY=1 for cycles t+1 to t+4.
  - DONE=1 in cycle t+5.
  - Latency is fixed at 5 cycles for every OP.
- Back-to-back throughput: one operation per 5 cycles, achieved when START is held or re-asserted in the DONE cycle.
- DONE and BUSY are never high together.
- Outputs are driven from registers only; there are no combinational paths from inputs to outputs.

## Structure
- Package alu_serial_pkg:
  - OP encodings OP_ADD, OP_SUB, OP_NOT, OP_NEG.
  - State encodings S_IDLE, S_CALC, S_DONE.
  - Constants NIB_W=4, NIB_CNT=4.
- Sub-module nibble_adder_4:
  - Purely combinational 4-bit ripple adder.
  - Inputs: two 4-bit operands and carry-in. Outputs: 4-bit sum, carry-out, and carry into bit 3.
  - One instance per unit.
- The existing NEGATOR_16 is instantiated once. Its input is muxed between A (for NEG and NOT) and B (for SUB); its output is latched as operand Y.

## Test plan
- ADD 0x1234+0x0FCD: Y=0x2201, C=0, Z=0, V=0, DONE exactly 5 cycles after START. ADD 0xFFFF+0x0001: Y=0x0000, C=1, Z=1, V=0.
- SUB 0x0005−0x0007: Y=0xFFFE, C=0, V=0. SUB 0x8000−0x0001: Y=0x7FFF, C=1, V=1.
- NEG 0x8000: Y=0x8000, C=0, V=1. NEG 0x0000: Y=0x0000, C=1, Z=1, V=0. NEG 0x0001: Y=0xFFFF.
- NOT 0x00FF: Y=0xFF00, C=0, V=0, Z=0. NOT 0xFFFF: Y=0x0000, Z=1.
- START pulsed in CALC cycle 2 with different operands: ignored, original result delivered. START in the DONE cycle: second DONE arrives 5 cycles later with the correct second result.
- RST asserted in the second CALC cycle: next cycle BUSY=0, Y=0, all flags 0, and no DONE follows. A subsequent START completes normally.
